// File: rtl/rng_pkg.sv
// Shared definitions for the round-robin shared random generator.
package rng_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StStep    = 2'd1,
        StDeliver = 2'd2,
        StLoad    = 2'd3
    } rng_state_e;

    // Reset seed, also substituted whenever a zero seed is requested
    localparam logic [31:0] RNG_DEFAULT_SEED = 32'hECEBCAFE;

    // xorshift32 shift amounts
    localparam int unsigned XS_SHIFT_A = 13;
    localparam int unsigned XS_SHIFT_B = 17;
    localparam int unsigned XS_SHIFT_C = 5;

endpackage

// File: rtl/xorshift32_step.sv
// One combinational xorshift32 step: x ^= x<<13; x ^= x>>17; x ^= x<<5.
module xorshift32_step
    import rng_pkg::*;
(
    input  logic [31:0] state_i,
    output logic [31:0] state_o
);

    logic [31:0] x_a;
    logic [31:0] x_b;

    // Three shift-xor stages applied in order
    always_comb begin
        x_a     = state_i ^ (state_i << XS_SHIFT_A);
        x_b     = x_a ^ (x_a >> XS_SHIFT_B);
        state_o = x_b ^ (x_b << XS_SHIFT_C);
    end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one xorshift32 generator among N_REQ requesters.
// A draw is STEP (advance generator) then DELIVER (register ack/data); the
// registered ack and data appear in the IDLE cycle that follows DELIVER.
module rng_arbiter
    import rng_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter logic [31:0] SEED  = RNG_DEFAULT_SEED
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         ack,
    output logic [7:0]               rnd_data,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    input  logic                     seed_load,
    input  logic [31:0]              seed_in,
    output logic                     busy,
    output logic [15:0]              draw_count
);

    localparam int unsigned     IdW    = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] AckOne = N_REQ'(1);

    rng_state_e       fsm_q, fsm_d;
    logic [31:0]      rng_q, rng_d;
    logic [31:0]      rng_next;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [7:0]       rnd_q, rnd_d;
    logic             busy_q, busy_d;
    logic [15:0]      count_q, count_d;
    logic             seed_pend_q, seed_pend_d;
    logic [31:0]      seed_lat_q, seed_lat_d;

    logic             rr_found;
    logic [IdW-1:0]   rr_pick;
    logic [IdW-1:0]   rr_idx;

    xorshift32_step u_step (
        .state_i (rng_q),
        .state_o (rng_next)
    );

    // Round-robin search: first set req bit at or after rr_ptr, wrapping
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            rr_idx = IdW'((int'(rr_ptr_q) + i) % int'(N_REQ));
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state; a pending reseed wins over draws
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            StIdle: begin
                if (seed_pend_q) begin
                    fsm_d = StLoad;
                end else if (rr_found) begin
                    fsm_d = StStep;
                end
            end
            StStep:    fsm_d = StDeliver;
            StDeliver: fsm_d = StIdle;
            StLoad:    fsm_d = StIdle;
            default:   fsm_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values decoded from the FSM
    always_comb begin
        rng_d       = rng_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        ack_d       = '0;
        rnd_d       = rnd_q;
        count_d     = count_q;
        busy_d      = (fsm_d != StIdle);
        seed_pend_d = seed_pend_q;
        seed_lat_d  = seed_lat_q;

        case (fsm_q)
            StIdle: begin
                if (!seed_pend_q && rr_found) begin
                    grant_d = rr_pick;
                end
            end
            StStep: begin
                rng_d = rng_next;
            end
            StDeliver: begin
                ack_d    = AckOne << grant_q;
                rnd_d    = rng_q[15:8];
                rr_ptr_d = (grant_q == IdW'(N_REQ - 1)) ? '0 : grant_q + IdW'(1);
                count_d  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            end
            StLoad: begin
                // Zero is a fixed point of xorshift, so never load it
                rng_d       = (seed_lat_q == 32'd0) ? SEED : seed_lat_q;
                seed_pend_d = 1'b0;
            end
            default: ;
        endcase

        // A new pulse in any state (even LOAD) re-arms with the latest value
        if (seed_load) begin
            seed_pend_d = 1'b1;
            seed_lat_d  = seed_in;
        end
    end

    // Datapath and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rng_q       <= SEED;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            ack_q       <= '0;
            rnd_q       <= '0;
            busy_q      <= 1'b0;
            count_q     <= '0;
            seed_pend_q <= 1'b0;
            seed_lat_q  <= '0;
        end else begin
            rng_q       <= rng_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_q       <= ack_d;
            rnd_q       <= rnd_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            seed_pend_q <= seed_pend_d;
            seed_lat_q  <= seed_lat_d;
        end
    end

    assign ack        = ack_q;
    assign rnd_data   = rnd_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign draw_count = count_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter: stimulus pushes expected draws, a monitor
// pops and compares whenever ack is seen.
module tb_rng_arbiter;
    import rng_pkg::*;

    localparam int unsigned NR = 4;

    logic          Clk;
    logic          Reset_n;
    logic [NR-1:0] req;
    logic [NR-1:0] ack;
    logic [7:0]    rnd_data;
    logic [1:0]    grant_id;
    logic          seed_load;
    logic [31:0]   seed_in;
    logic          busy;
    logic [15:0]   draw_count;

    rng_arbiter #(
        .N_REQ (NR),
        .SEED  (RNG_DEFAULT_SEED)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req        (req),
        .ack        (ack),
        .rnd_data   (rnd_data),
        .grant_id   (grant_id),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .busy       (busy),
        .draw_count (draw_count)
    );

    // Golden generator step
    logic [31:0] g_in;
    logic [31:0] g_out;
    logic [31:0] m_state;

    xorshift32_step u_gold (
        .state_i (g_in),
        .state_o (g_out)
    );

    typedef struct packed {
        logic [NR-1:0] ack_v;
        logic [7:0]    rnd_v;
        logic [1:0]    id_v;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model once and queue the draw it predicts for requester id
    task automatic expect_draw(input int id);
        exp_t e;
        g_in = m_state;
        #1;
        m_state = g_out;
        e.ack_v = 4'b0001 << id;
        e.rnd_v = m_state[15:8];
        e.id_v  = 2'(id);
        exp_q.push_back(e);
    endtask

    // Called at a negedge; one isolated draw, req dropped right after grant
    task automatic draw_one(input logic [NR-1:0] reqv, input int id,
                            input logic [7:0] hand, input bit has_hand);
        expect_draw(id);
        req = reqv;
        @(negedge Clk);
        req = '0;
        check("busy_step", busy, 1);
        check("ack_step", ack, 0);
        @(negedge Clk);
        check("busy_deliver", busy, 1);
        check("ack_deliver", ack, 0);
        @(negedge Clk);
        check("ack_latency", ack, 32'(1) << id);
        check("busy_after", busy, 0);
        if (has_hand) check("rnd_hand", rnd_data, hand);
    endtask

    // Called at a negedge with the FSM idle; pulse seed_load and follow LOAD
    task automatic do_seed(input logic [31:0] v);
        logic [7:0] rnd_before;
        rnd_before = rnd_data;
        seed_load  = 1'b1;
        seed_in    = v;
        @(negedge Clk);
        seed_load = 1'b0;
        check("seed_busy_k", busy, 0);
        @(negedge Clk);
        check("seed_busy_load", busy, 1);
        @(negedge Clk);
        check("seed_busy_done", busy, 0);
        check("seed_rnd_hold", rnd_data, rnd_before);
        m_state = (v == 32'd0) ? RNG_DEFAULT_SEED : v;
    endtask

    // Monitor: every ack pulse must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ack", ack, e.ack_v);
                    check("sb_rnd", rnd_data, e.rnd_v);
                    check("sb_grant", grant_id, e.id_v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        req       = '0;
        seed_load = 1'b0;
        seed_in   = '0;
        m_state   = RNG_DEFAULT_SEED;
        g_in      = '0;
        Reset_n   = 1'b1;
        #1;
        Reset_n   = 1'b0;

        // Reset values
        @(negedge Clk);
        @(negedge Clk);
        check("rst_ack", ack, 0);
        check("rst_rnd", rnd_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_count", draw_count, 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // All four requesting for 8 draws from the reset seed
        for (int d = 0; d < 8; d++) expect_draw(d % 4);
        @(negedge Clk);
        req = 4'b1111;
        for (int d = 0; d < 8; d++) begin
            @(negedge Clk);
            check("held_busy", busy, 1);
            @(negedge Clk);
            @(negedge Clk);
            check("held_order", ack, 32'(1) << (d % 4));
        end
        req = '0;
        @(negedge Clk);
        check("held_count", draw_count, 8);

        // Seed 1: hand-computed states 00042021 then 04080601
        do_seed(32'h0000_0001);
        draw_one(4'b0001, 0, 8'h20, 1'b1);
        draw_one(4'b0001, 0, 8'h06, 1'b1);
        check("count_10", draw_count, 10);

        // Zero seed falls back to the reset seed
        do_seed(32'h0000_0000);
        draw_one(4'b0001, 0, 8'h00, 1'b0);

        // Reseed during STEP of requester 2 with requester 0 left pending
        expect_draw(2);
        m_state = 32'h1234_5678;
        expect_draw(0);
        @(negedge Clk);
        req = 4'b0100;
        @(negedge Clk);
        req       = 4'b0001;
        seed_load = 1'b1;
        seed_in   = 32'h1234_5678;
        @(negedge Clk);
        seed_load = 1'b0;
        check("mid_busy_deliver", busy, 1);
        @(negedge Clk);
        check("mid_ack2", ack, 4'b0100);
        @(negedge Clk);
        check("mid_busy_load", busy, 1);
        check("mid_ack_load", ack, 0);
        @(negedge Clk);
        check("mid_idle_after_load", busy, 0);
        @(negedge Clk);
        check("mid_busy_step", busy, 1);
        req = '0;
        @(negedge Clk);
        @(negedge Clk);
        check("mid_ack0", ack, 4'b0001);
        @(negedge Clk);

        // req[1] dropped after grant still draws; pointer then favours 2 over 1
        draw_one(4'b0010, 1, 8'h00, 1'b0);
        draw_one(4'b0110, 2, 8'h00, 1'b0);

        // Reset during DELIVER abandons the draw
        @(negedge Clk);
        req = 4'b0001;
        @(negedge Clk);
        req = '0;
        @(negedge Clk);
        check("abort_in_deliver", busy, 1);
        Reset_n = 1'b0;
        #1;
        check("abort_ack", ack, 0);
        check("abort_busy", busy, 0);
        check("abort_rnd", rnd_data, 0);
        check("abort_grant", grant_id, 0);
        check("abort_count", draw_count, 0);
        @(negedge Clk);
        @(negedge Clk);
        check("abort_no_ack", ack, 0);
        Reset_n = 1'b1;
        m_state = RNG_DEFAULT_SEED;
        @(negedge Clk);
        draw_one(4'b0001, 0, 8'h00, 1'b0);
        check("abort_count_after", draw_count, 1);

        // Drain scoreboard with a bounded wait
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge Clk);
        check("sb_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
